counter_bank: RTL and testbench
===============================

# counter_bank

Bank of `CHANNELS` independent, parametrised `WIDTH`-bit counters. It generalises the fixed 8-bit, up-only, wrap-only counter and adds:

- per-channel enable, direction and parallel load;
- wrap or saturate overflow modes;
- terminal-count pulses and sticky overflow flags.

It sits beside the design's timebase/event logic as the shared counting resource. An optional build cascades the channels into one `CHANNELS*WIDTH`-bit counter.

## Interface
- `WIDTH`, 8, bits per channel counter (≥2)
- `CHANNELS`, 4, number of counter channels (≥1)
- `clk`  input  1  clock, all state changes on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `en`  input  CHANNELS  per-channel count enable
- `dir`  input  CHANNELS  per-channel direction: 1 = up, 0 = down
- `sat`  input  CHANNELS  per-channel mode: 1 = saturate, 0 = wrap
- `load`  input  CHANNELS  per-channel parallel load strobe
- `load_val`  input  CHANNELS*WIDTH  load values; channel i at `[i*WIDTH +: WIDTH]`
- `clr_ovf`  input  CHANNELS  per-channel sticky-overflow clear
- `cnt`  output  CHANNELS*WIDTH  registered counter values, same packing as `load_val`
- `tc`  output  CHANNELS  registered terminal-count pulse, one cycle
- `ovf`  output  CHANNELS  registered sticky overflow flag

## Operation
- Priority per channel, evaluated each rising edge: `rst` > `load` > count event > hold.
- **Count event:** `en[i]` high and `load[i]` low (see Configuration for channels > 0).
- **Boundary:** a count event with `dir=1` and `cnt==2^WIDTH-1`, or with `dir=0` and `cnt==0`.
- **Up, non-boundary:** `cnt` ← `cnt+1`. **Down, non-boundary:** `cnt` ← `cnt-1`. Arithmetic is modulo `2^WIDTH`; no carry leaves the channel except via `tc`.
- **Boundary, wrap mode (`sat=0`):** `cnt` wraps (MAX→0 up, 0→MAX down).
- **Boundary, saturate mode (`sat=1`):** `cnt` holds MAX (up) or 0 (down).
- **Boundary, either mode:** `tc[i]`=1 for exactly the following cycle, and `ovf[i]` is set.
- `tc[i]`=0 on every non-boundary cycle, including load cycles and hold cycles.
- Repeated boundary events in saturate mode pulse `tc` every cycle while held at the limit with `en` high.
- **Load:** `cnt[i]` ← `load_val[i]`. No `tc`. `ovf` is unaffected except by `clr_ovf`.
- **`clr_ovf[i]`:** clears `ovf[i]`. If a boundary event occurs in the same cycle, set wins and `ovf[i]` stays 1.
- `dir` and `sat` changes take effect on the next count event. There is no internal state other than `cnt`, `tc` and `ovf`.

## Timing
- **Reset values:** all `cnt`=0, all `tc`=0, all `ovf`=0. Reset applied mid-count clears everything on that edge and overrides `load`/`en`.
- **Latency:** inputs sampled at edge N; `cnt`/`tc`/`ovf` reflect them after edge N (one-cycle latency). No combinational input→output path.
- Channels are fully independent unless cascade is compiled in.
- **Load and enable in the same cycle:** load wins and no count occurs.

## Configuration
- Macro: `COUNTER_BANK_CASCADE_EN`.
- **Defined:**
  - For i>0, the channel i count event = `en[i]` & (combinational boundary event of channel i-1 in the same cycle) & !`load[i]`.
  - Channel 0 is unchanged.
  - With all `en`=1 and matching `dir`, the bank behaves as one `CHANNELS*WIDTH`-bit counter; the top channel's `tc` marks full-width wrap/saturation.
  - Saturation remains per channel, so all `sat` bits must match for full-width saturate semantics; this is a usage rule, not checked.
- **Undefined:** channels are independent; `en[i]` alone gates channel i.

## Test plan
All tests use `WIDTH=8`, `CHANNELS=4`.
- **Reset/count:** `rst` 2 cycles, then ch0 `en=1 dir=1 sat=0` for 260 cycles.
  - Required: `cnt0` 0→255→0→…→4.
  - Required: `tc0` pulses once, on the cycle `cnt0` shows 0 after 255.
  - Required: `ovf0`=1.
- **Saturate/down:** ch1 load 3, then `en=1 dir=0 sat=1` for 6 cycles.
  - Required: `cnt1` 2,1,0,0,0,0.
  - Required: `tc1` high on the last 3 cycles.
  - Required: `ovf1`=1.
- **Priority:** ch2 `en=1 load=1 load_val=0xA5` with `rst=1`.
  - Required: `cnt2`=0.
  - Next cycle, same inputs with `rst=0`: required `cnt2`=0xA5, `tc2`=0.
- **Overflow clear race:** ch3 at 255 up, wrap, `clr_ovf=1` same cycle.
  - Required: `ovf3`=1.
  - Next cycle `clr_ovf=1` with no boundary: required `ovf3`=0.
- **Cascade (macro defined):** all `en=1 dir=1 sat=0`, load ch0=0xFF, ch1=0xFF, ch2=0x00.
  - Required, one cycle later: ch0=0x00, ch1=0x00, ch2=0x01, `tc0`=`tc1`=1.
  - Required, without macro: ch0=0x00, ch1=0x00, ch2=0x01, ch3 incremented too (all independent).
- **Reset mid-operation:** `rst` pulsed 1 cycle while all channels count.
  - Required: all outputs 0 the next cycle.
  - Required: counting resumes from 0 (cascade build: ch1–3 stay 0 until ch0 reaches its boundary).

Source files
------------

// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent WIDTH-bit up/down counters with wrap or saturate,
// terminal-count pulses and sticky overflow flags. Define COUNTER_BANK_CASCADE_EN to chain channels.
module counter_bank #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       sat,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    input  logic [CHANNELS-1:0]       clr_ovf,
    output logic [CHANNELS*WIDTH-1:0] cnt,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       ovf
);

    localparam logic [WIDTH-1:0] MAXV = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [CHANNELS*WIDTH-1:0] r_cnt;
    logic [CHANNELS-1:0]       r_tc;
    logic [CHANNELS-1:0]       r_ovf;

    logic [CHANNELS*WIDTH-1:0] w_cnt_nxt;
    logic [CHANNELS-1:0]       w_bnd;

    always_comb begin
        logic [WIDTH-1:0] cur;
        logic             ev;
        logic             bnd;
`ifdef COUNTER_BANK_CASCADE_EN
        logic             carry;
        carry = 1'b1;
`endif
        cur       = '0;
        ev        = 1'b0;
        bnd       = 1'b0;
        w_cnt_nxt = r_cnt;
        w_bnd     = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cur = r_cnt[i*WIDTH +: WIDTH];
`ifdef COUNTER_BANK_CASCADE_EN
            // carry holds the previous channel's same-cycle boundary; channel 0 sees constant 1
            ev    = en[i] & ~load[i] & carry;
`else
            ev    = en[i] & ~load[i];
`endif
            bnd   = ev & (dir[i] ? (cur == MAXV) : (cur == '0));
`ifdef COUNTER_BANK_CASCADE_EN
            carry = bnd;
`endif
            w_bnd[i] = bnd;
            if (load[i]) begin
                w_cnt_nxt[i*WIDTH +: WIDTH] = load_val[i*WIDTH +: WIDTH];
            end else if (ev && !(bnd && sat[i])) begin
                // modulo arithmetic gives the wrap-mode boundary result directly
                w_cnt_nxt[i*WIDTH +: WIDTH] = dir[i] ? (cur + ONE) : (cur - ONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_tc  <= '0;
            r_ovf <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_tc  <= w_bnd;
            // a boundary in the same cycle as clr_ovf keeps the flag set
            r_ovf <= w_bnd | (r_ovf & ~clr_ovf);
        end
    end

    assign cnt = r_cnt;
    assign tc  = r_tc;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: directed vector table, test-plan sequences and
// randomized stimulus against a behavioural model (honours COUNTER_BANK_CASCADE_EN).
module tb_counter_bank;

    localparam int W = 8;
    localparam int C = 4;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [C-1:0]   en, dir, sat, load, clr_ovf;
    logic [C*W-1:0] load_val;
    logic [C*W-1:0] cnt;
    logic [C-1:0]   tc, ovf;

    counter_bank #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .cnt(cnt), .tc(tc), .ovf(ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_cnt[C];
    bit m_tc[C];
    bit m_ovf[C];

    function automatic void model_step();
        bit prev_bnd;
        bit gate;
        bit ev;
        bit bnd;
        int lim;
        prev_bnd = 1'b1;
        if (rst) begin
            for (int i = 0; i < C; i++) begin
                m_cnt[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
            end
            return;
        end
        for (int i = 0; i < C; i++) begin
            gate = 1'b1;
`ifdef COUNTER_BANK_CASCADE_EN
            gate = (i == 0) || prev_bnd;
`endif
            lim = dir[i] ? MAXV : 0;
            ev  = en[i] && !load[i] && gate;
            bnd = ev && (m_cnt[i] == lim);
            prev_bnd = bnd;
            m_tc[i]  = bnd;
            if (bnd) m_ovf[i] = 1'b1;
            else if (clr_ovf[i]) m_ovf[i] = 1'b0;
            if (load[i]) m_cnt[i] = int'(load_val[i*W +: W]);
            else if (ev && !(bnd && sat[i]))
                m_cnt[i] = (m_cnt[i] + (dir[i] ? 1 : MAXV)) % (MAXV + 1);
        end
    endfunction

    function automatic logic [C*W-1:0] exp_cnt();
        logic [C*W-1:0] v;
        v = '0;
        for (int i = 0; i < C; i++) v[i*W +: W] = W'(m_cnt[i]);
        return v;
    endfunction

    function automatic logic [C-1:0] exp_bits(input bit sel_ovf);
        logic [C-1:0] v;
        v = '0;
        for (int i = 0; i < C; i++) v[i] = sel_ovf ? m_ovf[i] : m_tc[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [C*W-1:0] act, input logic [C*W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("model_cnt", cnt, exp_cnt());
        chk("model_tc", {{(C*W-C){1'b0}}, tc}, {{(C*W-C){1'b0}}, exp_bits(1'b0)});
        chk("model_ovf", {{(C*W-C){1'b0}}, ovf}, {{(C*W-C){1'b0}}, exp_bits(1'b1)});
    endtask

    task automatic idle_inputs();
        rst = 1'b0; en = '0; dir = '0; sat = '0; load = '0; clr_ovf = '0; load_val = '0;
    endtask

    typedef struct {
        logic           rst;
        logic [C-1:0]   en, dir, sat, load, clr;
        logic [C*W-1:0] lv;
        logic [C*W-1:0] e_cnt;
        logic [C-1:0]   e_tc, e_ovf;
    } vec_t;

    vec_t tbl[11];
    int   b_exp[6];
    int   pulses;

    initial begin
        tbl[0]  = '{1'b1, 4'b0101, 4'b0001, 4'b0000, 4'b0101, 4'b0000, 32'h00A5_00FE, 32'h0000_0000, 4'h0, 4'h0};
        tbl[1]  = '{1'b0, 4'b0101, 4'b0001, 4'b0000, 4'b0101, 4'b0000, 32'h00A5_00FE, 32'h00A5_00FE, 4'h0, 4'h0};
        tbl[2]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'h0,         32'h00A5_00FF, 4'h0, 4'h0};
        tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'h0,         32'h00A5_0000, 4'h1, 4'h1};
        tbl[4]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 32'h0,         32'h00A5_0001, 4'h0, 4'h0};
        tbl[5]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0,         32'h00A5_0000, 4'h0, 4'h0};
        tbl[6]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 32'h0,         32'h00A5_0000, 4'h1, 4'h1};
        tbl[7]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 32'h0,         32'h00A5_0000, 4'h1, 4'h1};
        tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 32'h0,         32'h00A5_0000, 4'h0, 4'h0};
        tbl[9]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 32'h0000_00FF, 32'h00A5_00FF, 4'h0, 4'h0};
        tbl[10] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 32'h0,         32'h00A5_00FF, 4'h1, 4'h1};

        idle_inputs();

        // Directed vector table
        for (int k = 0; k < 11; k++) begin
            rst = tbl[k].rst; en = tbl[k].en; dir = tbl[k].dir; sat = tbl[k].sat;
            load = tbl[k].load; clr_ovf = tbl[k].clr; load_val = tbl[k].lv;
            cycle();
            chk($sformatf("vec%0d_cnt", k), cnt, tbl[k].e_cnt);
            chk($sformatf("vec%0d_tc", k), {28'h0, tc}, {28'h0, tbl[k].e_tc});
            chk($sformatf("vec%0d_ovf", k), {28'h0, ovf}, {28'h0, tbl[k].e_ovf});
        end

        // Reset then 260 up-counts on ch0 in wrap mode
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_cnt", cnt, '0);
        chk("reset_tc", {28'h0, tc}, '0);
        chk("reset_ovf", {28'h0, ovf}, '0);
        rst = 1'b0; en = 4'b0001; dir = 4'b0001;
        pulses = 0;
        for (int k = 0; k < 260; k++) begin
            cycle();
            if (tc[0] === 1'b1) pulses++;
        end
        chk("wrap_tc0_pulses", pulses, 1);
        chk("wrap_cnt0_final", cnt[7:0], 8'd4);
        chk("wrap_ovf0", ovf[0], 1'b1);

        // Saturating down-count on ch1; ch0 sits at 0 in saturate-down so it also feeds a cascade
        idle_inputs();
        load = 4'b0011; load_val = 32'h0000_0300;
        cycle();
        load = '0; en = 4'b0011; dir = 4'b0000; sat = 4'b0011;
        b_exp = '{2, 1, 0, 0, 0, 0};
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk($sformatf("satdn_cnt1_%0d", k), cnt[15:8], 8'(b_exp[k]));
            chk($sformatf("satdn_tc1_%0d", k), tc[1], (k >= 3) ? 1'b1 : 1'b0);
        end
        chk("satdn_ovf1", ovf[1], 1'b1);

        // Overflow-clear race on ch3; ch0..2 held at a boundary so the cascade build also counts ch3
        idle_inputs();
        load = 4'b1111; load_val = 32'hFF00_0000;
        cycle();
        load = '0; en = 4'b1111; dir = 4'b1000; sat = 4'b0111; clr_ovf = 4'b1000;
        cycle();
        chk("race_cnt3", cnt[31:24], 8'h00);
        chk("race_tc3", tc[3], 1'b1);
        chk("race_ovf3", ovf[3], 1'b1);
        en = '0; clr_ovf = 4'b1000;
        cycle();
        chk("clr_ovf3", ovf[3], 1'b0);

        // Carry chain behaviour
        idle_inputs();
        load = 4'b1111; load_val = 32'h0000_FFFF;
        cycle();
        load = '0; en = 4'b1111; dir = 4'b1111;
        cycle();
        chk("casc_low", cnt[23:0], 24'h01_0000);
`ifdef COUNTER_BANK_CASCADE_EN
        chk("casc_ch3", cnt[31:24], 8'h00);
`else
        chk("casc_ch3", cnt[31:24], 8'h01);
`endif
        chk("casc_tc01", tc[1:0], 2'b11);

        // Reset while every channel counts, with load also asserted
        repeat (5) cycle();
        rst = 1'b1; load = 4'b1111; load_val = 32'h1234_5678;
        cycle();
        chk("midrst_cnt", cnt, '0);
        chk("midrst_tc", {28'h0, tc}, '0);
        chk("midrst_ovf", {28'h0, ovf}, '0);
        rst = 1'b0; load = '0;
        cycle();
`ifdef COUNTER_BANK_CASCADE_EN
        chk("resume_cnt", cnt, 32'h0000_0001);
`else
        chk("resume_cnt", cnt, 32'h0101_0101);
`endif

        // Randomized stimulus against the model, load values biased to the limits
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(0, 199) == 0);
            en       = 4'($urandom | $urandom);
            dir      = 4'($urandom);
            sat      = 4'($urandom);
            load     = 4'($urandom & $urandom & $urandom);
            clr_ovf  = 4'($urandom & $urandom);
            for (int i = 0; i < C; i++) begin
                case ($urandom_range(0, 4))
                    0: load_val[i*W +: W] = 8'h00;
                    1: load_val[i*W +: W] = 8'hFF;
                    2: load_val[i*W +: W] = 8'hFE;
                    3: load_val[i*W +: W] = 8'h01;
                    default: load_val[i*W +: W] = 8'($urandom);
                endcase
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
